fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/lzc24.sv | 17 +
 rtl/fp_mul_seq.sv | 177 +++++++++++++++++
 tb/tb_fp_mul_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 constants, operand classes and the fp_mul_seq state encoding.
package fpu_pkg;

    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_DONE
    } mul_state_e;

    // Classify one binary32 operand from its exponent and fraction fields.
    function automatic fp_class_e classify(input logic [31:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == '1) begin
            return (f != '0) ? CLS_NAN : CLS_INF;
        end
        if (e == '0) begin
            return (f != '0) ? CLS_SUB : CLS_ZERO;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/lzc24.sv
// Leading-zero count of a 24-bit significand; an all-zero input reports 24.
module lzc24 (
    input  logic [23:0] i_sig,
    output logic [4:0]  o_lz
);

    // Scan upward so the highest set bit decides the count.
    always_comb begin
        o_lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (i_sig[i]) begin
                o_lz = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential binary32 multiplier: unpack, 24-cycle shift-add, normalise,
// round-to-nearest-even, flush-to-zero on underflow, saturate to inf on overflow.
module fp_mul_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A_IN,
    input  logic [31:0] B_IN,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] R_OUT,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    mul_state_e         r_state, w_next;
    logic [4:0]         r_cnt;

    logic [31:0]        r_a, r_b;
    logic               r_sign;
    fp_class_e          r_cla, r_clb;
    logic [23:0]        r_ma, r_mb;
    logic signed [9:0]  r_exp;
    logic [47:0]        r_prod;
    logic [23:0]        r_man;
    logic               r_guard, r_sticky;
    logic [31:0]        r_res;
    logic               r_ovf, r_unf, r_inv;

    fp_class_e          w_cla, w_clb;
    logic [23:0]        w_siga_raw, w_sigb_raw, w_siga, w_sigb;
    logic [4:0]         w_lza, w_lzb;
    logic signed [9:0]  w_ea, w_eb, w_exp_sum;
    logic [47:0]        w_pp;
    logic [24:0]        w_rnd;
    logic [22:0]        w_frac_f;
    logic signed [9:0]  w_exp_f;
    logic [31:0]        w_res;
    logic               w_ovf, w_unf, w_inv;

    function automatic logic rne_up(input logic [23:0] man, input logic g, input logic s);
        return g & (s | man[0]);
    endfunction

    // Returns {overflow, underflow, word}: saturate high exponents, flush low ones.
    function automatic logic [33:0] sat_pack(input logic sign, input logic signed [9:0] exp,
                                             input logic [22:0] frac);
        if (exp >= 10'sd255) return {2'b10, sign, 8'hFF, 23'd0};
        if (exp <= 10'sd0)   return {2'b01, sign, 31'd0};
        return {2'b00, sign, exp[7:0], frac};
    endfunction

    lzc24 u_lzc_a (.i_sig(w_siga_raw), .o_lz(w_lza));
    lzc24 u_lzc_b (.i_sig(w_sigb_raw), .o_lz(w_lzb));

    // Unpack both captured operands: class, normalised significand, effective exponents.
    always_comb begin
        w_cla      = classify(r_a);
        w_clb      = classify(r_b);
        w_siga_raw = {(r_a[30:23] != 8'd0), r_a[22:0]};
        w_sigb_raw = {(r_b[30:23] != 8'd0), r_b[22:0]};
        w_siga     = (w_cla == CLS_SUB) ? (w_siga_raw << w_lza) : w_siga_raw;
        w_sigb     = (w_clb == CLS_SUB) ? (w_sigb_raw << w_lzb) : w_sigb_raw;
        w_ea       = (w_cla == CLS_SUB) ? (10'sd1 - $signed({5'd0, w_lza}))
                                        : $signed({2'd0, r_a[30:23]});
        w_eb       = (w_clb == CLS_SUB) ? (10'sd1 - $signed({5'd0, w_lzb}))
                                        : $signed({2'd0, r_b[30:23]});
        w_exp_sum  = w_ea + w_eb - $signed(10'(BIAS));
        w_pp       = {24'd0, r_ma} << r_cnt;
    end

    // Round the normalised mantissa and pick the final word and flag.
    always_comb begin
        w_rnd    = {1'b0, r_man} + {24'd0, rne_up(r_man, r_guard, r_sticky)};
        w_frac_f = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
        w_exp_f  = r_exp + (w_rnd[24] ? 10'sd1 : 10'sd0);
        w_res    = 32'd0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_inv    = 1'b0;
        if (r_cla == CLS_NAN || r_clb == CLS_NAN ||
            (r_cla == CLS_INF && r_clb == CLS_ZERO) ||
            (r_cla == CLS_ZERO && r_clb == CLS_INF)) begin
            w_res = CANON_NAN;
            w_inv = 1'b1;
        end else if (r_cla == CLS_INF || r_clb == CLS_INF) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else if (r_cla == CLS_ZERO || r_clb == CLS_ZERO) begin
            w_res = {r_sign, 31'd0};
        end else begin
            {w_ovf, w_unf, w_res} = sat_pack(r_sign, w_exp_f, w_frac_f);
        end
    end

    // State register and multiply-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_MUL && r_cnt != 5'd23) ? r_cnt + 5'd1 : 5'd0;
        end
    end

    // Next-state logic: fixed walk through the pipeline, wait for the consumer in DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_PREP;
            S_PREP:  w_next = S_MUL;
            S_MUL:   if (r_cnt == 5'd23) w_next = S_NORM;
            S_NORM:  w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs; result and flags are only visible in DONE.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        R_OUT     = (r_state == S_DONE) ? r_res : 32'd0;
        overflow  = (r_state == S_DONE) & r_ovf;
        underflow = (r_state == S_DONE) & r_unf;
        invalid   = (r_state == S_DONE) & r_inv;
    end

    // Datapath registers, advanced by the current state.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_a <= A_IN;
                    r_b <= B_IN;
                end
            end
            S_PREP: begin
                r_sign <= r_a[31] ^ r_b[31];
                r_cla  <= w_cla;
                r_clb  <= w_clb;
                r_ma   <= w_siga;
                r_mb   <= w_sigb;
                r_exp  <= w_exp_sum;
                r_prod <= 48'd0;
            end
            S_MUL: begin
                if (r_mb[r_cnt]) r_prod <= r_prod + w_pp;
            end
            S_NORM: begin
                if (r_prod[47]) begin
                    r_man    <= r_prod[47:24];
                    r_guard  <= r_prod[23];
                    r_sticky <= |r_prod[22:0];
                    r_exp    <= r_exp + 10'sd1;
                end else begin
                    r_man    <= r_prod[46:23];
                    r_guard  <= r_prod[22];
                    r_sticky <= |r_prod[21:0];
                end
            end
            S_ROUND: begin
                r_res <= w_res;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
                r_inv <= w_inv;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed vectors, hold/ignore window,
// mid-operation reset, and randomized operands against a real-arithmetic model.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A_IN, B_IN;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R_OUT;
    logic        overflow, underflow, invalid;

    int n_tests = 0;
    int n_fail  = 0;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A_IN(A_IN), .B_IN(B_IN), .out_valid(out_valid), .out_ready(out_ready),
        .R_OUT(R_OUT), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, invalid, underflow, overflow};
    endfunction

    // Magnitude of a binary32 pattern as an exact real.
    function automatic real f2r(input logic [31:0] x);
        int   e;
        int   m;
        logic [63:0] sc;
        e = int'(x[30:23]);
        if (e == 0) begin
            m = int'({9'd0, x[22:0]});
            e = 1;
        end else begin
            m = int'({8'd0, 1'b1, x[22:0]});
        end
        sc = {1'b0, 11'(1023 + e - 150), 52'd0};
        return real'(m) * $bitstoreal(sc);
    endfunction

    // Reference: returns {invalid, underflow, overflow, word}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, s, up;
        logic [63:0] pb;
        logic [22:0] keep, frac;
        logic [24:0] sum;
        int          e, be;
        real         p;
        sgn    = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            return {3'b100, 32'h7FC0_0000};
        if (a_inf || b_inf) return {3'b000, sgn, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {3'b000, sgn, 31'd0};
        p    = f2r(a) * f2r(b);
        pb   = $realtobits(p);
        e    = int'(pb[62:52]) - 1023;
        keep = pb[51:29];
        g    = pb[28];
        s    = |pb[27:0];
        up   = g & (s | keep[0]);
        sum  = {2'b01, keep} + {24'd0, up};
        if (sum[24]) begin
            e++;
            frac = sum[23:1];
        end else begin
            frac = sum[22:0];
        end
        be = e + 127;
        if (be >= 255) return {3'b001, sgn, 8'hFF, 23'd0};
        if (be <= 0)   return {3'b010, sgn, 31'd0};
        return {3'b000, sgn, be[7:0], frac};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3, 4: r[30:23] = 8'($urandom_range(100, 154));
            5:             r[30:23] = 8'd0;
            6:             r[30:23] = 8'($urandom_range(1, 20));
            7:             r[30:23] = 8'($urandom_range(230, 254));
            8: begin
                case ($urandom_range(0, 2))
                    0:       r[30:0] = 31'd0;
                    1:       r[30:0] = {8'hFF, 23'd0};
                    default: r[30:0] = {8'hFF, 1'b1, 22'($urandom)};
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        A_IN     = a;
        B_IN     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_vld_low"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy_high"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_flags_idle"}, flags(), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [34:0] exp);
        int lat;
        issue(a, b);
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'd27);
        check({tag, "_res"}, R_OUT, exp[31:0]);
        check({tag, "_flags"}, flags(), {29'd0, exp[34:32]});
        handshake(tag);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A_IN      = '0;
        B_IN      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_res", R_OUT, 32'd0);
        check("rst_flags", flags(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_rdy", {31'd0, in_ready}, 32'd1);

        run_op("d_2x3",     32'h4000_0000, 32'h4040_0000, {3'b000, 32'h40C0_0000});
        run_op("d_rne",     32'h3F80_0001, 32'h3F80_0001, {3'b000, 32'h3F80_0002});
        run_op("d_1p5sq",   32'h3FC0_0000, 32'h3FC0_0000, {3'b000, 32'h4010_0000});
        run_op("d_subn",    32'h0040_0000, 32'h4000_0000, {3'b000, 32'h0080_0000});
        run_op("d_unf",     32'h0080_0000, 32'h0080_0000, {3'b010, 32'h0000_0000});
        run_op("d_ovf",     32'h7F00_0000, 32'hFF00_0000, {3'b001, 32'hFF80_0000});
        run_op("d_inf0",    32'h7F80_0000, 32'h0000_0000, {3'b100, 32'h7FC0_0000});
        run_op("d_infneg",  32'hFF80_0000, 32'h3F80_0000, {3'b000, 32'hFF80_0000});
        run_op("d_zneg",    32'h8000_0000, 32'h4000_0000, {3'b000, 32'h8000_0000});
        run_op("d_nan",     32'h3F80_0000, 32'hFFC0_0001, {3'b100, 32'h7FC0_0000});

        // Consumer stalls for 10 cycles; a new operand offered meanwhile must be dropped.
        issue(32'h4000_0000, 32'h4040_0000);
        wait_out(lat);
        check("hold_lat", 32'(lat), 32'd27);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                A_IN     = 32'h3F80_0000;
                B_IN     = 32'h3F80_0000;
                in_valid = 1'b1;
            end
            if (i == 8) in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("hold_res", R_OUT, 32'h40C0_0000);
            check("hold_flags", flags(), 32'd0);
            check("hold_rdy", {31'd0, in_ready}, 32'd0);
            check("hold_vld", {31'd0, out_valid}, 32'd1);
        end
        handshake("hold");
        seen = 0;
        repeat (35) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("hold_no_queue", 32'(seen), 32'd0);

        // Reset in the middle of the multiply loop.
        issue(32'h4000_0000, 32'h4040_0000);
        repeat (13) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check("mid_rst_res", R_OUT, 32'd0);
        check("mid_rst_flags", flags(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (35) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("mid_rst_stale", 32'(seen), 32'd0);
        run_op("post_rst", 32'h3FC0_0000, 32'h3FC0_0000, {3'b000, 32'h4010_0000});

        for (int n = 0; n < 150; n++) begin
            ra = rnd_fp();
            rb = rnd_fp();
            run_op("rand", ra, rb, model(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
